// File: rtl/proc_context_unit.sv
// Process-context/relocation unit: per-process base/limit/saved-PC table plus a round-robin quantum scheduler.
// Optional build macro PCU_FAULT_KILL_EN: an address fault during RUN terminates the running process.
module proc_context_unit #(
  parameter int ADDR_W    = 32,
  parameter int NPROC     = 8,
  parameter int QUANTUM_W = 16,
  localparam int PID_W    = $clog2(NPROC)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 CfgWrite,
  input  logic [PID_W-1:0]     CfgPID,
  input  logic [ADDR_W-1:0]    CfgBase,
  input  logic [ADDR_W-1:0]    CfgLimit,
  input  logic [ADDR_W-1:0]    CfgEntryPC,
  input  logic                 CfgQuantumWrite,
  input  logic [QUANTUM_W-1:0] CfgQuantum,
  input  logic                 Start,
  input  logic                 YieldReq,
  input  logic                 ExitReq,
  input  logic [ADDR_W-1:0]    CorePC,
  input  logic [ADDR_W-1:0]    LogicalAddr,
  input  logic                 AccessValid,
  output logic [ADDR_W-1:0]    PhysAddr,
  output logic                 AddrFault,
  output logic [PID_W-1:0]     FaultPID,
  output logic [PID_W-1:0]     CurPID,
  output logic                 Stall,
  output logic [ADDR_W-1:0]    RestorePC,
  output logic                 SwitchPulse,
  output logic                 Idle
);

  // state   | meaning
  // IDLE    | no runnable process, waiting for Start
  // SELECT  | scanning one slot per cycle for the next valid process
  // RESTORE | loading the selected context, SwitchPulse high
  // RUN     | process executing, quantum counting down
  // SAVE    | storing CorePC of the outgoing process
  typedef enum logic [2:0] {IDLE, SELECT, RESTORE, RUN, SAVE} state_t;

  state_t               state;
  logic                 valid   [NPROC];
  logic [ADDR_W-1:0]    base    [NPROC];
  logic [ADDR_W-1:0]    limit   [NPROC];
  logic [ADDR_W-1:0]    savedPc [NPROC];
  logic [QUANTUM_W-1:0] reloadQ;
  logic [QUANTUM_W-1:0] counter;
  logic [PID_W-1:0]     ptr;
  logic [PID_W-1:0]     scanCnt;
  logic [PID_W-1:0]     cand;
  logic                 killFault;

  assign PhysAddr  = LogicalAddr + base[CurPID];
  assign AddrFault = AccessValid && (LogicalAddr >= limit[CurPID]);
  assign cand      = ptr + 1'b1;

`ifdef PCU_FAULT_KILL_EN
  assign killFault = AddrFault;
`else
  assign killFault = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NPROC; i++) begin
        valid[i]   <= 1'b0;
        base[i]    <= '0;
        limit[i]   <= '0;
        savedPc[i] <= '0;
      end
      reloadQ     <= QUANTUM_W'(1000);
      counter     <= '0;
      ptr         <= '0;
      scanCnt     <= '0;
      state       <= IDLE;
      CurPID      <= '0;
      FaultPID    <= '0;
      Stall       <= 1'b1;
      SwitchPulse <= 1'b0;
      RestorePC   <= '0;
      Idle        <= 1'b1;
    end else begin
      SwitchPulse <= 1'b0;
      if (AddrFault) FaultPID <= CurPID;

      case (state)
        IDLE: begin
          if (Start) begin
            ptr     <= PID_W'(NPROC - 1);
            scanCnt <= '0;
            Idle    <= 1'b0;
            state   <= SELECT;
          end
        end
        RUN: begin
          counter <= counter - 1'b1;
          if (ExitReq || killFault) begin
            valid[CurPID] <= 1'b0;
            ptr           <= CurPID;
            scanCnt       <= '0;
            Stall         <= 1'b1;
            state         <= SELECT;
          end else if (YieldReq || counter <= QUANTUM_W'(1)) begin
            Stall <= 1'b1;
            state <= SAVE;
          end
        end
        SAVE: begin
          savedPc[CurPID] <= CorePC;
          ptr             <= CurPID;
          scanCnt         <= '0;
          state           <= SELECT;
        end
        SELECT: begin
          ptr <= cand;
          if (valid[cand]) begin
            CurPID      <= cand;
            RestorePC   <= savedPc[cand];
            SwitchPulse <= 1'b1;
            state       <= RESTORE;
          end else if (scanCnt == PID_W'(NPROC - 1)) begin
            Idle  <= 1'b1;
            state <= IDLE;
          end else begin
            scanCnt <= scanCnt + 1'b1;
          end
        end
        RESTORE: begin
          counter <= reloadQ;
          Stall   <= 1'b0;
          state   <= RUN;
        end
        default: state <= IDLE;
      endcase

      // Configuration writes land last so they override a same-cycle save or exit.
      if (CfgWrite) begin
        base[CfgPID]    <= CfgBase;
        limit[CfgPID]   <= CfgLimit;
        savedPc[CfgPID] <= CfgEntryPC;
        valid[CfgPID]   <= (CfgLimit != '0);
      end
      if (CfgQuantumWrite) reloadQ <= CfgQuantum;
    end
  end

endmodule
